add_bist: RTL and testbench

- Hardware self-test initiator for the registered adder (ports a, b, y; result registered one clock after operands).
- On a start pulse it issues four fixed directed operand pairs, then a programmable number of pseudo-random pairs, at one pair per cycle.
- It compares each returned sum against an internally pipelined expected value and reports the vector count, error count, first failing vector and pass/fail.
- It sits beside the adder in the top level and drives the adder's a/b; the adder's y feeds back into this block.

---
 rtl/add_bist_pkg.sv | 32 +++
 rtl/add_bist_lfsr_gen.sv | 39 +++
 rtl/add_bist.sv | 244 ++++++++++++++++++++++++
 tb/tb_add_bist.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_bist_pkg.sv
// Shared types and constants for the adder self-test initiator.
// Directed operands are held at 64 bits and truncated to the instance width.
package add_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAX_W   = 64;
  localparam int NUM_DIR = 4;

  localparam logic [7:0] DEF_TAPS = 8'hB8;

  // Truncation keeps MAX all-ones and the alternating pair complementary at any width.
  localparam logic [MAX_W-1:0] DIR_A [NUM_DIR] = '{
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0001,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hAAAA_AAAA_AAAA_AAAA
  };

  localparam logic [MAX_W-1:0] DIR_B [NUM_DIR] = '{
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0002,
    64'h0000_0000_0000_0001,
    64'h5555_5555_5555_5555
  };

endpackage

// File: rtl/add_bist_lfsr_gen.sv
// Galois LFSR operand source; an all-zero seed is promoted to 1 so the
// register can never lock up.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == {WIDTH{1'b0}}) ? WIDTH'(1'b1) : seed;
    end else if (step) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? TAPS : {WIDTH{1'b0}});
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/add_bist.sv
// Self-test initiator for a registered adder: issues directed then LFSR
// operand pairs, checks returned sums against a delayed expected value.
module add_bist
  import add_bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 16,
  parameter int               LAT   = 1,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int IDX_W = CNT_W + 1;
  localparam int DRN_W = $clog2(LAT + 1) + 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } exp_entry_t;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DRN_W-1:0]     drain_q, drain_d;
  logic [CNT_W-1:0]     num_vec_q, num_vec_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic                 op_vld_q, op_vld_d;
  exp_entry_t [LAT-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic             run_start;
  logic             lfsr_step;
  logic [WIDTH-1:0] lfsr_a, lfsr_b, seed_b;
  logic [IDX_W-1:0] last_idx;
  exp_entry_t       tail;
  logic             chk;
  logic             mis;

  assign seed_b   = ~seed;
  assign last_idx = {1'b0, num_vec_q} + IDX_W'(NUM_DIR - 1);
  assign tail     = pipe_q[LAT-1];
  assign chk      = tail.valid;
  assign mis      = chk && (sum_y != tail.sum);

  lfsr_gen #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (run_start),
    .seed (seed),
    .step (lfsr_step),
    .q    (lfsr_a)
  );

  lfsr_gen #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (run_start),
    .seed (seed_b),
    .step (lfsr_step),
    .q    (lfsr_b)
  );

  // Operands are registered, so vector idx appears on op_a/op_b one cycle after ISSUE selects it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    num_vec_d = num_vec_q;
    op_a_d    = {WIDTH{1'b0}};
    op_b_d    = {WIDTH{1'b0}};
    op_vld_d  = 1'b0;
    run_start = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          run_start = 1'b1;
          num_vec_d = num_vec;
          idx_d     = {IDX_W{1'b0}};
          state_d   = ISSUE;
        end else begin
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        op_vld_d = 1'b1;
        if (idx_q < IDX_W'(NUM_DIR)) begin
          op_a_d = DIR_A[idx_q[1:0]][WIDTH-1:0];
          op_b_d = DIR_B[idx_q[1:0]][WIDTH-1:0];
        end else begin
          op_a_d    = lfsr_a;
          op_b_d    = lfsr_b;
          lfsr_step = 1'b1;
        end
        if (idx_q == last_idx) begin
          drain_d = {DRN_W{1'b0}};
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      // One extra drain cycle covers the operand register ahead of the adder.
      DRAIN: begin
        if (drain_q == DRN_W'(LAT)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = op_vld_q;
    pipe_d[0].a     = op_a_q;
    pipe_d[0].b     = op_b_q;
    pipe_d[0].sum   = op_a_q + op_b_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    fail_a_d  = fail_a_q;
    fail_b_d  = fail_b_q;
    if (run_start) begin
      vec_cnt_d = {CNT_W{1'b0}};
      err_cnt_d = {CNT_W{1'b0}};
      fail_a_d  = {WIDTH{1'b0}};
      fail_b_d  = {WIDTH{1'b0}};
    end else if (chk) begin
      if (vec_cnt_q != {CNT_W{1'b1}}) begin
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
      end else begin
        vec_cnt_d = vec_cnt_q;
      end
      if (mis) begin
        if (err_cnt_q == {CNT_W{1'b0}}) begin
          fail_a_d = tail.a;
          fail_b_d = tail.b;
        end else begin
          fail_a_d = fail_a_q;
        end
        if (err_cnt_q != {CNT_W{1'b1}}) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      vec_cnt_d = vec_cnt_q;
    end
  end

  // pass reflects the final count, which includes the compare landing in the same cycle.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    pass_d = pass_q;
    if (state_d == DONE) begin
      pass_d = (err_cnt_d == {CNT_W{1'b0}});
    end else if (run_start) begin
      pass_d = 1'b0;
    end else begin
      pass_d = pass_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= {IDX_W{1'b0}};
      drain_q   <= {DRN_W{1'b0}};
      num_vec_q <= {CNT_W{1'b0}};
      op_a_q    <= {WIDTH{1'b0}};
      op_b_q    <= {WIDTH{1'b0}};
      op_vld_q  <= 1'b0;
      pipe_q    <= '0;
      vec_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
      fail_a_q  <= {WIDTH{1'b0}};
      fail_b_q  <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      num_vec_q <= num_vec_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_vld_q  <= op_vld_d;
      pipe_q    <= pipe_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      fail_a_q  <= fail_a_d;
      fail_b_q  <= fail_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;
  assign fail_a  = fail_a_q;
  assign fail_b  = fail_b_q;

endmodule

// File: tb/tb_add_bist.sv
// Randomized bench for add_bist against a run-level model of the self-test,
// driving a behavioural registered adder with an optional stuck-at fault.
module tb_add_bist;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 16;
  localparam int         LAT   = 1;
  localparam logic [7:0] TAPS  = 8'hB8;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        start   = 1'b0;
  logic [15:0] num_vec = 16'd0;
  logic [7:0]  seed    = 8'd0;
  logic [7:0]  sum_y   = 8'd0;
  logic        fault_en = 1'b0;
  logic [7:0]  op_a, op_b, fail_a, fail_b;
  logic        busy, done, pass;
  logic [15:0] vec_cnt, err_cnt;

  int tests = 0;
  int fails = 0;

  add_bist #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LAT(LAT), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .seed(seed),
    .op_a(op_a), .op_b(op_b), .sum_y(sum_y), .busy(busy), .done(done),
    .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .fail_a(fail_a), .fail_b(fail_b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] adder_out(input logic [7:0] a, input logic [7:0] b, input logic f);
    logic [7:0] s;
    s = a + b;
    return f ? (s & 8'hFE) : s;
  endfunction

  // Registered adder under test (one cycle latency), optionally with y[0] stuck at 0.
  always @(posedge clk) sum_y <= adder_out(op_a, op_b, fault_en);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] galois(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 8'h00);
  endfunction

  // Run model: vector list, which vectors the adder gets wrong, and edges since start.
  logic [7:0] m_a[$];
  logic [7:0] m_b[$];
  bit         m_bad[$];
  int         m_n = 0;
  int         m_t = 0;
  bit         m_busy = 1'b0;
  bit         m_ran = 1'b0;

  task automatic build_run();
    logic [7:0] sa, sb, nseed, s;
    m_a.delete(); m_b.delete(); m_bad.delete();
    m_a.push_back(8'h00); m_b.push_back(8'h00);
    m_a.push_back(8'h01); m_b.push_back(8'h02);
    m_a.push_back(8'hFF); m_b.push_back(8'h01);
    m_a.push_back(8'hAA); m_b.push_back(8'h55);
    nseed = ~seed;
    sa = (seed == 8'h00) ? 8'h01 : seed;
    sb = (nseed == 8'h00) ? 8'h01 : nseed;
    for (int j = 0; j < int'(num_vec); j++) begin
      m_a.push_back(sa); m_b.push_back(sb);
      sa = galois(sa); sb = galois(sb);
    end
    m_n = 4 + int'(num_vec);
    for (int k = 0; k < m_n; k++) begin
      s = m_a[k] + m_b[k];
      m_bad.push_back(adder_out(m_a[k], m_b[k], fault_en) != s);
    end
    m_t = 0; m_busy = 1'b1; m_ran = 1'b1;
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 1'b0; m_ran = 1'b0;
      end else if (m_busy) begin
        m_t++;
        if (m_t == m_n + LAT + 2) m_busy = 1'b0;
      end else if (start) begin
        build_run();
      end
    end
  end

  initial begin : compare
    int t, c, errs;
    bit found;
    logic [7:0]  e_fa, e_fb, e_opa, e_opb;
    logic [15:0] e_vec, e_err;
    logic        e_busy, e_done, e_pass;
    forever begin
      @(negedge clk);
      e_fa = 8'h00; e_fb = 8'h00; e_opa = 8'h00; e_opb = 8'h00;
      e_vec = 16'h0; e_err = 16'h0; e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
      if (!rst && m_ran) begin
        t = m_busy ? m_t : m_n + LAT + 2;
        c = t - 1 - LAT;
        if (c < 0) c = 0;
        if (c > m_n) c = m_n;
        errs = 0; found = 1'b0;
        for (int k = 0; k < c; k++) begin
          if (m_bad[k]) begin
            errs++;
            if (!found) begin found = 1'b1; e_fa = m_a[k]; e_fb = m_b[k]; end
          end
        end
        e_vec  = (c > 65535) ? 16'hFFFF : 16'(c);
        e_err  = (errs > 65535) ? 16'hFFFF : 16'(errs);
        e_busy = m_busy;
        e_done = m_busy && (t == m_n + LAT + 1);
        if (m_busy && t >= 1 && t <= m_n) begin
          e_opa = m_a[t-1]; e_opb = m_b[t-1];
        end
        e_pass = (t >= m_n + LAT + 1) && (errs == 0);
      end
      chk("op_a", 32'(op_a), 32'(e_opa));
      chk("op_b", 32'(op_b), 32'(e_opb));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("pass", 32'(pass), 32'(e_pass));
      chk("vec_cnt", 32'(vec_cnt), 32'(e_vec));
      chk("err_cnt", 32'(err_cnt), 32'(e_err));
      chk("fail_a", 32'(fail_a), 32'(e_fa));
      chk("fail_b", 32'(fail_b), 32'(e_fb));
    end
  end

  logic [7:0] rec_a[$];
  logic [7:0] rec_b[$];

  // Starts a run and records operands; rec_a[k] holds vector k. cyc = edges to done, -1 if reset.
  task automatic do_run(input logic [15:0] nv, input logic [7:0] sd, input int pulse_at,
                        input int rst_at, output int cyc);
    int limit;
    @(negedge clk);
    num_vec = nv; seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rec_a.delete(); rec_b.delete();
    cyc = 0;
    limit = int'(nv) + LAT + 50;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      rec_a.push_back(op_a); rec_b.push_back(op_b);
      start = (i == pulse_at);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
          @(negedge clk);
          chk("rst_no_done", 32'(done), 32'd0);
        end
        cyc = -1;
        return;
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
    start = 1'b0;
    if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin : driver
    int cyc;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_run(16'd0, 8'h01, 0, 0, cyc);
    chk("s1_done_edges", 32'(cyc), 32'd6);
    chk("s1_vec_cnt", 32'(vec_cnt), 32'd4);
    chk("s1_err_cnt", 32'(err_cnt), 32'd0);
    chk("s1_pass", 32'(pass), 32'd1);
    chk("s1_v1_a", 32'(rec_a[1]), 32'd1);
    chk("s1_v1_b", 32'(rec_b[1]), 32'd2);
    chk("s1_v2_a", 32'(rec_a[2]), 32'd255);
    chk("s1_v2_b", 32'(rec_b[2]), 32'd1);
    chk("s1_v3_a", 32'(rec_a[3]), 32'd170);
    chk("s1_v3_b", 32'(rec_b[3]), 32'd85);

    do_run(16'd3, 8'h01, 0, 0, cyc);
    chk("s2_done_edges", 32'(cyc), 32'd9);
    chk("s2_rand0", 32'(rec_a[4]), 32'h01);
    chk("s2_rand1", 32'(rec_a[5]), 32'hB8);
    chk("s2_rand2", 32'(rec_a[6]), 32'h5C);
    chk("s2_vec_cnt", 32'(vec_cnt), 32'd7);
    chk("s2_pass", 32'(pass), 32'd1);

    fault_en = 1'b1;
    do_run(16'd0, 8'h01, 0, 0, cyc);
    chk("s3_fail_a", 32'(fail_a), 32'd1);
    chk("s3_fail_b", 32'(fail_b), 32'd2);
    chk("s3_err_cnt", 32'(err_cnt), 32'd2);
    chk("s3_pass", 32'(pass), 32'd0);
    fault_en = 1'b0;

    do_run(16'd3, 8'h01, 3, 0, cyc);
    chk("s4_vec_cnt", 32'(vec_cnt), 32'd7);
    chk("s4_pass", 32'(pass), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      chk("s4_single_done", 32'(done), 32'd0);
      chk("s4_idle_busy", 32'(busy), 32'd0);
    end

    do_run(16'd20, 8'h5A, 0, 6, cyc);
    do_run(16'd5, 8'h33, 0, 0, cyc);
    chk("s5_vec_cnt", 32'(vec_cnt), 32'd9);
    chk("s5_pass", 32'(pass), 32'd1);

    do_run(16'd2, 8'h00, 0, 0, cyc);
    chk("s6_rand_a", 32'(rec_a[4]), 32'h01);
    chk("s6_rand_b", 32'(rec_b[4]), 32'hFF);
    chk("s6_pass", 32'(pass), 32'd1);

    do_run(16'd2, 8'hFF, 0, 0, cyc);
    chk("s7_rand_a", 32'(rec_a[4]), 32'hFF);
    chk("s7_rand_b", 32'(rec_b[4]), 32'h01);

    for (int r = 0; r < 10; r++) begin
      fault_en = ($urandom_range(0, 3) == 0);
      do_run(16'($urandom_range(0, 40)), 8'($urandom), 0, 0, cyc);
    end
    fault_en = 1'b0;
    do_run(16'd300, 8'($urandom), 0, 0, cyc);
    chk("long_vec_cnt", 32'(vec_cnt), 32'd304);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
